pulse_measurer: RTL and testbench

Receive-side counterpart of the pulse sequencer. Samples an asynchronous pulse train and measures the length of each high phase and the following low phase in clock cycles. Reports each high/low pair as reload values in the sequencer's convention: phase length minus one. A measured pair written into a sequencer's hi/lo count registers reproduces the same waveform. The block sits on the input side of the timing fabric, next to the photon/strobe inputs, and is read by the register interface.

---
 rtl/pulse_pkg.sv | 15 +
 rtl/edge_sync.sv | 30 +++
 rtl/pulse_measurer.sv | 161 ++++++++++++++++
 tb/tb_pulse_measurer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse measurement/sequencing blocks.
package pulse_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAlign,
      StMeasHi,
      StMeasLo
   } meas_state_e;

   localparam int unsigned DefaultWidth = 32;
   // Also sizes the pair counter field in the sequencer's register map.
   localparam int unsigned PairCountW = 16;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input, plus a history flop for edge detection.
module edge_sync #(
   parameter int unsigned Stages = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [Stages-1:0] sync_q;
   logic              hist_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[Stages-2:0], in_i};
         hist_q <= sync_q[Stages-1];
      end
   end

   assign level_o = sync_q[Stages-1];
   assign rise_o  = sync_q[Stages-1] & ~hist_q;
   assign fall_o  = ~sync_q[Stages-1] & hist_q;

endmodule

// File: rtl/pulse_measurer.sv
// Measures high/low phase pairs of an asynchronous pulse train and reports them as
// length-minus-one reload values with a valid/ack handshake.
module pulse_measurer
   import pulse_pkg::*;
#(
   parameter int unsigned WIDTH       = DefaultWidth,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  operate_i,
   input  logic                  in_i,
   input  logic                  ack_i,
   output logic [WIDTH-1:0]      hi_count_o,
   output logic [WIDTH-1:0]      lo_count_o,
   output logic                  valid_o,
   output logic                  saturated_o,
   output logic                  overrun_o,
   output logic [PairCountW-1:0] pair_count_o
);

   localparam logic [WIDTH-1:0] CntMax = '1;

   meas_state_e           state_q, state_d;
   logic [WIDTH-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]      pend_hi_q, pend_hi_d;
   logic                  sat_hi_q, sat_hi_d;
   logic [WIDTH-1:0]      hi_q, hi_d;
   logic [WIDTH-1:0]      lo_q, lo_d;
   logic                  valid_q, valid_d;
   logic                  sat_q, sat_d;
   logic                  ovr_q, ovr_d;
   logic [PairCountW-1:0] pairs_q, pairs_d;
   logic                  operate_q;

   logic                  in_level, in_rise, in_fall;
   logic                  pair_done;
   logic                  cnt_at_max;
   logic [WIDTH-1:0]      cnt_inc;

   edge_sync #(
      .Stages(SYNC_STAGES)
   ) u_edge_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .in_i   (in_i),
      .level_o(in_level),
      .rise_o (in_rise),
      .fall_o (in_fall)
   );

   assign cnt_at_max = (cnt_q == CntMax);
   assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + WIDTH'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      sat_hi_d  = sat_hi_q;
      pair_done = 1'b0;
      if (!operate_i) begin
         state_d   = StIdle;
         cnt_d     = '0;
         pend_hi_d = '0;
         sat_hi_d  = 1'b0;
      end else begin
         case (state_q)
            StIdle: state_d = StAlign;
            StAlign: begin
               if (in_rise) begin
                  state_d = StMeasHi;
                  cnt_d   = '0;
               end
            end
            StMeasHi: begin
               if (in_fall) begin
                  pend_hi_d = cnt_q;
                  sat_hi_d  = cnt_at_max;
                  cnt_d     = '0;
                  state_d   = StMeasLo;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            StMeasLo: begin
               // MeasLo is only entered on a fall, so the first high sample here is the rise.
               if (in_level) begin
                  pair_done = 1'b1;
                  cnt_d     = '0;
                  state_d   = StMeasHi;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      sat_d   = sat_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      pairs_d = pairs_q;
      if (operate_i && !operate_q) begin
         ovr_d = 1'b0;
      end
      if (pair_done) begin
         // A same-cycle ack frees the slot, so the new pair replaces the old one.
         if (!valid_q || ack_i) begin
            hi_d    = pend_hi_q;
            lo_d    = cnt_q;
            sat_d   = sat_hi_q | cnt_at_max;
            valid_d = 1'b1;
            pairs_d = pairs_q + PairCountW'(1);
         end else begin
            ovr_d = 1'b1;
         end
      end else if (ack_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         sat_hi_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         valid_q   <= 1'b0;
         sat_q     <= 1'b0;
         ovr_q     <= 1'b0;
         pairs_q   <= '0;
         operate_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         sat_hi_q  <= sat_hi_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         valid_q   <= valid_d;
         sat_q     <= sat_d;
         ovr_q     <= ovr_d;
         pairs_q   <= pairs_d;
         operate_q <= operate_i;
      end
   end

   assign hi_count_o   = hi_q;
   assign lo_count_o   = lo_q;
   assign valid_o      = valid_q;
   assign saturated_o  = sat_q;
   assign overrun_o    = ovr_q;
   assign pair_count_o = pairs_q;

endmodule

// File: tb/tb_pulse_measurer.sv
// Bench for pulse_measurer: a 32-bit and a 4-bit instance share one stimulus stream and are
// checked every cycle against a run-length model, plus literal expectations per scenario.
module tb_pulse_measurer;

   localparam int Stages = 2;
   localparam longint MaxWide   = (64'sd1 <<< 32) - 1;
   localparam longint MaxNarrow = 15;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic operate_i = 1'b0;
   logic in_i = 1'b0;
   logic ack_i = 1'b0;

   logic [31:0] hi_w, lo_w;
   logic        valid_w, sat_w, ovr_w;
   logic [15:0] pc_w;
   logic [3:0]  hi_n, lo_n;
   logic        valid_n, sat_n, ovr_n;
   logic [15:0] pc_n;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pulse_measurer #(
      .WIDTH(32),
      .SYNC_STAGES(Stages)
   ) u_dut_wide (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .operate_i   (operate_i),
      .in_i        (in_i),
      .ack_i       (ack_i),
      .hi_count_o  (hi_w),
      .lo_count_o  (lo_w),
      .valid_o     (valid_w),
      .saturated_o (sat_w),
      .overrun_o   (ovr_w),
      .pair_count_o(pc_w)
   );

   pulse_measurer #(
      .WIDTH(4),
      .SYNC_STAGES(Stages)
   ) u_dut_narrow (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .operate_i   (operate_i),
      .in_i        (in_i),
      .ack_i       (ack_i),
      .hi_count_o  (hi_n),
      .lo_count_o  (lo_n),
      .valid_o     (valid_n),
      .saturated_o (sat_n),
      .overrun_o   (ovr_n),
      .pair_count_o(pc_n)
   );

   // Model works on full phase lengths; counts are derived as min(length - 1, max).
   typedef struct {
      bit          op_prev;
      bit          plvl;
      int          phase;   // 0: waiting for a rise, 1: in high phase, 2: in low phase
      longint      run;
      longint      hi_len;
      longint      hi_cnt;
      longint      lo_cnt;
      bit          valid;
      bit          sat;
      bit          ov;
      bit [15:0]   pc;
   } mdl_t;

   mdl_t mw, mn;
   bit   dly [Stages];

   function automatic mdl_t mdl_step(input mdl_t m, input bit op, input bit ack, input bit lvl,
                                     input longint maxc);
      bit     rise;
      bit     done;
      longint lo_len;
      rise   = lvl && !m.plvl;
      done   = 1'b0;
      lo_len = 0;
      // The first operate cycle is spent leaving idle; no edge is accepted then.
      if (!op || !m.op_prev) begin
         m.phase = 0;
      end else begin
         case (m.phase)
            0: if (rise) begin m.phase = 1; m.run = 1; end
            1: if (lvl) m.run++;
               else begin m.hi_len = m.run; m.phase = 2; m.run = 1; end
            default: if (!lvl) m.run++;
               else begin done = 1'b1; lo_len = m.run; m.phase = 1; m.run = 1; end
         endcase
      end
      if (op && !m.op_prev) m.ov = 1'b0;
      if (done) begin
         if (!m.valid || ack) begin
            m.hi_cnt = (m.hi_len - 1 > maxc) ? maxc : m.hi_len - 1;
            m.lo_cnt = (lo_len - 1 > maxc) ? maxc : lo_len - 1;
            m.sat    = (m.hi_len - 1 >= maxc) || (lo_len - 1 >= maxc);
            m.valid  = 1'b1;
            m.pc     = m.pc + 16'd1;
         end else begin
            m.ov = 1'b1;
         end
      end else if (ack) begin
         m.valid = 1'b0;
      end
      m.op_prev = op;
      m.plvl    = lvl;
      return m;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic phase(input bit v, input int n);
      in_i = v;
      cyc(n);
   endtask

   task automatic pulse_ack();
      ack_i = 1'b1;
      cyc(1);
      ack_i = 1'b0;
   endtask

   // Per-cycle comparison against the model.
   initial begin
      mw = '{default: 0};
      mn = '{default: 0};
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            mw = '{default: 0};
            mn = '{default: 0};
            for (int i = 0; i < Stages; i++) dly[i] = 1'b0;
         end
         chk("cyc.w.hi", hi_w, mw.hi_cnt);
         chk("cyc.w.lo", lo_w, mw.lo_cnt);
         chk("cyc.w.valid", valid_w, mw.valid);
         chk("cyc.w.sat", sat_w, mw.sat);
         chk("cyc.w.ovr", ovr_w, mw.ov);
         chk("cyc.w.pc", pc_w, mw.pc);
         chk("cyc.n.hi", hi_n, mn.hi_cnt);
         chk("cyc.n.lo", lo_n, mn.lo_cnt);
         chk("cyc.n.valid", valid_n, mn.valid);
         chk("cyc.n.sat", sat_n, mn.sat);
         chk("cyc.n.ovr", ovr_n, mn.ov);
         chk("cyc.n.pc", pc_n, mn.pc);
         if (rst_ni) begin
            mw = mdl_step(mw, operate_i, ack_i, dly[Stages-1], MaxWide);
            mn = mdl_step(mn, operate_i, ack_i, dly[Stages-1], MaxNarrow);
            for (int i = Stages - 1; i > 0; i--) dly[i] = dly[i-1];
            dly[0] = in_i;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      cyc(3);
      chk("reset.hi", hi_w, 0);
      chk("reset.lo", lo_w, 0);
      chk("reset.valid", valid_w, 0);
      chk("reset.sat", sat_w, 0);
      chk("reset.ovr", ovr_w, 0);
      chk("reset.pc", pc_w, 0);
      rst_ni = 1'b1;
      cyc(1);

      // Basic pair: high 5, low 3 -> 4/2.
      operate_i = 1'b1;
      phase(0, 4); phase(1, 5); phase(0, 3); phase(1, 3);
      chk("basic.hi", hi_w, 4);
      chk("basic.lo", lo_w, 2);
      chk("basic.valid", valid_w, 1);
      chk("basic.pc", pc_w, 1);
      pulse_ack();
      chk("basic.ack_valid", valid_w, 0);

      // Overrun: pairs 4/4 (loaded) then 7/7 (dropped), then 2/2 after ack.
      phase(0, 4); phase(1, 7); phase(0, 7); phase(1, 2);
      in_i = 1'b0;
      cyc(1);
      chk("ovr.hi", hi_w, 3);
      chk("ovr.lo", lo_w, 3);
      chk("ovr.valid", valid_w, 1);
      chk("ovr.flag", ovr_w, 1);
      chk("ovr.pc", pc_w, 2);
      pulse_ack();
      chk("ovr.ack_valid", valid_w, 0);
      chk("ovr.sticky", ovr_w, 1);
      phase(1, 3);
      chk("ovr.third_hi", hi_w, 1);
      chk("ovr.third_lo", lo_w, 1);
      chk("ovr.third_valid", valid_w, 1);
      chk("ovr.third_pc", pc_w, 3);
      pulse_ack();

      // Re-raising operate clears the sticky overrun.
      operate_i = 1'b0;
      cyc(2);
      operate_i = 1'b1;
      cyc(1);
      chk("oprise.ovr", ovr_w, 0);

      // Ack coincident with completion: pair 3/3 pending, then 5/2 completes under ack.
      phase(0, 3); phase(1, 3); phase(0, 3); phase(1, 5); phase(0, 2);
      in_i = 1'b1;
      cyc(Stages);
      ack_i = 1'b1;
      cyc(1);
      ack_i = 1'b0;
      cyc(1);
      chk("coinc.hi", hi_w, 4);
      chk("coinc.lo", lo_w, 1);
      chk("coinc.valid", valid_w, 1);
      chk("coinc.ovr", ovr_w, 0);
      chk("coinc.pc", pc_w, 5);
      pulse_ack();

      // Abort mid-high, re-assert while high: nothing until a full rise-to-rise pair.
      operate_i = 1'b0;
      cyc(3);
      operate_i = 1'b1;
      cyc(3);
      phase(0, 3); phase(1, 4);
      chk("abort.valid", valid_w, 0);
      chk("abort.pc", pc_w, 5);
      phase(0, 2); phase(1, 3);
      chk("abort.hi", hi_w, 3);
      chk("abort.lo", lo_w, 1);
      chk("abort.pc2", pc_w, 6);
      pulse_ack();

      // Loopback of a sequencer programmed hi=7, lo=2: 20 acked pairs.
      phase(1, 4);
      for (int i = 0; i < 20; i++) begin
         phase(0, 3); phase(1, 4);
         ack_i = 1'b1;
         phase(1, 1);
         ack_i = 1'b0;
         phase(1, 3);
      end
      chk("loop.hi", hi_w, 7);
      chk("loop.lo", lo_w, 2);
      chk("loop.valid", valid_w, 0);
      chk("loop.ovr", ovr_w, 0);
      chk("loop.pc", pc_w, 26);

      // Saturation: 20-cycle high, 2-cycle low.
      phase(1, 12); phase(0, 2); phase(1, 3);
      chk("sat.n.hi", hi_n, 15);
      chk("sat.n.lo", lo_n, 1);
      chk("sat.n.sat", sat_n, 1);
      chk("sat.n.valid", valid_n, 1);
      chk("sat.w.hi", hi_w, 19);
      chk("sat.w.sat", sat_w, 0);

      // Asynchronous reset mid-cycle.
      #2;
      rst_ni = 1'b0;
      #1;
      chk("areset.hi", hi_w, 0);
      chk("areset.lo", lo_w, 0);
      chk("areset.valid", valid_w, 0);
      chk("areset.pc", pc_w, 0);
      chk("areset.n.sat", sat_n, 0);
      cyc(1);
      rst_ni = 1'b1;
      phase(0, 3); phase(1, 3); phase(0, 3); phase(1, 3);
      chk("post.hi", hi_w, 2);
      chk("post.lo", lo_w, 2);
      chk("post.pc", pc_w, 1);

      cyc(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
